// File: rtl/cheat_bank.sv
// Cheat/patch bank: address-matched data substitution slots with per-slot hit
// counters, plus NMI/IRQ vector hooking with holdoff and snescmd unlock logic.
module cheat_bank #(
  parameter int unsigned NUM_SLOTS        = 8,
  parameter int unsigned HOLDOFF_CYCLES   = 860000000,
  parameter int unsigned UNLOCK_WINDOW    = 72,
  parameter int unsigned AUTO_WINDOW_BITS = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] SNES_ADDR,
  input  logic [7:0]  SNES_DATA,
  input  logic        SNES_cycle_start,
  input  logic        SNES_reset_strobe,
  input  logic        snescmd_wr_strobe,
  input  logic [1:0]  pgm_sel,
  input  logic [3:0]  pgm_idx,
  input  logic        pgm_we,
  input  logic [31:0] pgm_in,
  input  logic [3:0]  stat_idx,
  output logic [7:0]  data_out,
  output logic        cheat_hit,
  output logic [3:0]  hit_slot,
  output logic [15:0] stat_count,
  output logic        snescmd_unlock
);

  localparam int unsigned SW = 4;
  localparam int unsigned HW = 30;
  localparam int unsigned UW = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW + 1) : 1;
  localparam int unsigned WW = AUTO_WINDOW_BITS;

  logic [NUM_SLOTS-1:0][23:0] addr_q;
  logic [NUM_SLOTS-1:0][7:0]  data_q;
  logic [NUM_SLOTS-1:0][15:0] cnt_q;
  logic [NUM_SLOTS-1:0]       en_q, os_q, spent_q;

  logic          cheat_en_q, nmi_en_q, irq_en_q, holdoff_en_q, hook_dis_q;
  logic [1:0]    hook_mode_q;
  logic          auto_nmi_q, auto_irq_q;
  logic [WW-1:0] win_q;
  logic [4:0]    nmi_cnt_q, irq_cnt_q;
  logic [1:0]    sync_dly_q;
  logic          nmi_sync_q, irq_sync_q, hook_sync_q;
  logic [HW-1:0] hold_q;
  logic [3:0]    tok_q;
  logic          temp_q;
  logic [UW-1:0] tdly_q;
  logic [15:0]   stat_q, stat_d;

  logic          any_match;
  logic [SW-1:0] win_idx;
  logic [7:0]    win_data;
  logic          is_ea, is_eb, is_ee, is_ef, is_vec;
  logic [8:0]    off;
  logic          snes_wr_ul, cmd_wr, pgm_ok, hold_load, hook_en, cyc_hit, tok_wr;
  logic          nmi_sel, irq_sel;

  function automatic logic [7:0] token_code(input logic [1:0] n);
    case (n)
      2'd0:    token_code = 8'h48;
      2'd1:    token_code = 8'h75;
      2'd2:    token_code = 8'h72;
      default: token_code = 8'h7A;
    endcase
  endfunction

  assign is_ea  = (SNES_ADDR == 24'h00FFEA);
  assign is_eb  = (SNES_ADDR == 24'h00FFEB);
  assign is_ee  = (SNES_ADDR == 24'h00FFEE);
  assign is_ef  = (SNES_ADDR == 24'h00FFEF);
  assign is_vec = is_ea | is_eb | is_ee | is_ef;
  assign off    = SNES_ADDR[8:0];

  assign snescmd_unlock = (&tok_q) | temp_q;
  assign snes_wr_ul     = snescmd_wr_strobe & snescmd_unlock;
  assign cmd_wr         = snes_wr_ul & (off == 9'h000);
  assign pgm_ok         = pgm_we & ~snes_wr_ul;
  assign tok_wr         = snescmd_wr_strobe & (off[8:2] == 7'h7D);
  assign hold_load      = (cmd_wr & (SNES_DATA == 8'h85)) | (SNES_reset_strobe & holdoff_en_q);
  assign hook_en        = (hold_q == '0) & ~hook_dis_q;
  assign cyc_hit        = SNES_cycle_start & cheat_en_q & any_match;
  assign nmi_sel        = (hook_mode_q == 2'd1) | ((hook_mode_q == 2'd3) & auto_nmi_q);
  assign irq_sel        = (hook_mode_q == 2'd2) | ((hook_mode_q == 2'd3) & auto_irq_q);

  // Lowest-index enabled, unspent slot on the current address wins.
  always_comb begin
    any_match = 1'b0;
    win_idx   = '0;
    win_data  = 8'h00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!any_match && en_q[i] && !spent_q[i] && (addr_q[i] == SNES_ADDR)) begin
        any_match = 1'b1;
        win_idx   = SW'(i);
        win_data  = data_q[i];
      end
    end
  end

  always_comb begin
    if (any_match)  data_out = win_data;
    else if (is_eb) data_out = 8'hB0;
    else if (is_ef) data_out = 8'hC4;
    else            data_out = 8'h2B;
  end

  assign hit_slot  = win_idx;
  assign cheat_hit = (cheat_en_q & any_match) |
                     (hook_sync_q & ((nmi_sync_q & nmi_en_q & (is_ea | is_eb)) |
                                     (irq_sync_q & irq_en_q & (is_ee | is_ef))));

  always_comb begin
    stat_d = 16'h0000;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (stat_idx == SW'(i)) stat_d = cnt_q[i];
    end
  end
  assign stat_count = stat_q;

  // Slot address/data payload carries no reset; it is only meaningful once enabled.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pgm_ok && (pgm_sel == 2'd0) && (pgm_idx == SW'(i))) begin
        addr_q[i] <= pgm_in[31:8];
        data_q[i] <= pgm_in[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      os_q    <= '0;
      spent_q <= '0;
      cnt_q   <= '0;
      stat_q  <= 16'h0000;
    end else begin
      stat_q <= stat_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cyc_hit && (win_idx == SW'(i))) begin
          if (cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
          if (os_q[i]) spent_q[i] <= 1'b1;
        end
        if (SNES_reset_strobe) spent_q[i] <= 1'b0;
        if (pgm_ok && (pgm_sel == 2'd0) && (pgm_idx == SW'(i))) begin
          spent_q[i] <= 1'b0;
          cnt_q[i]   <= 16'h0000;
        end
        if (pgm_ok && (pgm_sel == 2'd1) && (pgm_idx == SW'(i))) begin
          en_q[i] <= pgm_in[0];
          os_q[i] <= pgm_in[1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cheat_en_q   <= 1'b0;
      nmi_en_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      holdoff_en_q <= 1'b0;
      hook_dis_q   <= 1'b0;
      hook_mode_q  <= 2'd3;
      tok_q        <= 4'h0;
      hold_q       <= '0;
      temp_q       <= 1'b0;
      tdly_q       <= '0;
    end else begin
      if (pgm_ok && (pgm_sel == 2'd2)) begin
        {holdoff_en_q, irq_en_q, nmi_en_q, cheat_en_q} <=
          ({holdoff_en_q, irq_en_q, nmi_en_q, cheat_en_q} & ~pgm_in[7:4]) | pgm_in[3:0];
      end
      if (pgm_ok && (pgm_sel == 2'd3)) hook_mode_q <= pgm_in[1:0];
      if (cmd_wr) begin
        case (SNES_DATA)
          8'h82:   cheat_en_q <= 1'b1;
          8'h83:   cheat_en_q <= 1'b0;
          8'h84:   begin nmi_en_q <= 1'b0; irq_en_q <= 1'b0; end
          default: ;
        endcase
      end
      if (snes_wr_ul && (off == 9'h1FD)) hook_dis_q <= SNES_DATA[0];

      if (SNES_reset_strobe)                           tok_q <= 4'h0;
      else if (tok_wr && (SNES_DATA == token_code(off[1:0]))) tok_q[off[1:0]] <= 1'b1;
      else if (tok_wr)                                 tok_q <= 4'h0;

      if (hold_load)            hold_q <= HW'(HOLDOFF_CYCLES);
      else if (hold_q != '0)    hold_q <= hold_q - HW'(1);

      // A vector fetch opens a temporary unlock window counted in SNES cycles.
      if (SNES_cycle_start) begin
        if (is_vec) begin
          temp_q <= 1'b1;
          tdly_q <= UW'(UNLOCK_WINDOW);
        end else if (tdly_q == '0) begin
          temp_q <= 1'b0;
        end else begin
          tdly_q <= tdly_q - UW'(1);
        end
      end
    end
  end

  // Auto NMI/IRQ selection and the vector-synchronised hook enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_nmi_q  <= 1'b1;
      auto_irq_q  <= 1'b0;
      win_q       <= '1;
      nmi_cnt_q   <= 5'd0;
      irq_cnt_q   <= 5'd0;
      sync_dly_q  <= 2'd2;
      nmi_sync_q  <= 1'b0;
      irq_sync_q  <= 1'b0;
      hook_sync_q <= 1'b0;
    end else begin
      win_q <= win_q - WW'(1);
      if (win_q == '0) begin
        if (((nmi_cnt_q != 5'd0) && (irq_cnt_q != 5'd0)) || (irq_cnt_q == 5'd0)) begin
          auto_nmi_q <= 1'b1;
          auto_irq_q <= 1'b0;
        end else if (nmi_cnt_q == 5'd0) begin
          auto_nmi_q <= 1'b0;
          auto_irq_q <= 1'b1;
        end
        nmi_cnt_q <= 5'd0;
        irq_cnt_q <= 5'd0;
      end else if (SNES_cycle_start && !hook_dis_q) begin
        if (is_ea && (nmi_cnt_q != 5'h1F)) nmi_cnt_q <= nmi_cnt_q + 5'd1;
        if (is_ee && (irq_cnt_q != 5'h1F)) irq_cnt_q <= irq_cnt_q + 5'd1;
      end

      if (SNES_cycle_start) begin
        if (is_vec)                  sync_dly_q <= 2'd2;
        else if (sync_dly_q != 2'd0) sync_dly_q <= sync_dly_q - 2'd1;
      end
      if (sync_dly_q == 2'd0) begin
        nmi_sync_q  <= nmi_sel;
        irq_sync_q  <= irq_sel;
        hook_sync_q <= hook_en;
      end
    end
  end

endmodule

// File: tb/tb_cheat_bank.sv
// Directed self-checking bench for cheat_bank with shortened holdoff/window parameters.
module tb_cheat_bank;

  localparam int unsigned HOLD = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_DATA;
  logic        SNES_cycle_start, SNES_reset_strobe, snescmd_wr_strobe;
  logic [1:0]  pgm_sel;
  logic [3:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;
  logic [3:0]  stat_idx;
  logic [7:0]  data_out;
  logic        cheat_hit;
  logic [3:0]  hit_slot;
  logic [15:0] stat_count;
  logic        snescmd_unlock;

  int checks   = 0;
  int failures = 0;

  cheat_bank #(
    .NUM_SLOTS(8), .HOLDOFF_CYCLES(HOLD), .UNLOCK_WINDOW(4), .AUTO_WINDOW_BITS(6)
  ) dut (
    .clk(clk), .rst(rst), .SNES_ADDR(SNES_ADDR), .SNES_DATA(SNES_DATA),
    .SNES_cycle_start(SNES_cycle_start), .SNES_reset_strobe(SNES_reset_strobe),
    .snescmd_wr_strobe(snescmd_wr_strobe), .pgm_sel(pgm_sel), .pgm_idx(pgm_idx),
    .pgm_we(pgm_we), .pgm_in(pgm_in), .stat_idx(stat_idx), .data_out(data_out),
    .cheat_hit(cheat_hit), .hit_slot(hit_slot), .stat_count(stat_count),
    .snescmd_unlock(snescmd_unlock)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic pgm(input logic [1:0] sel, input logic [3:0] idx, input logic [31:0] val);
    pgm_sel = sel; pgm_idx = idx; pgm_in = val; pgm_we = 1'b1;
    tick(); pgm_we = 1'b0;
  endtask

  task automatic snes_cycle(input logic [23:0] a);
    SNES_ADDR = a; SNES_cycle_start = 1'b1;
    tick(); SNES_cycle_start = 1'b0;
  endtask

  task automatic snes_wr(input logic [8:0] o, input logic [7:0] d);
    SNES_ADDR = 24'h002A00 | {15'd0, o}; SNES_DATA = d; snescmd_wr_strobe = 1'b1;
    tick(); snescmd_wr_strobe = 1'b0;
  endtask

  task automatic unlock_tokens();
    snes_wr(9'h1F4, 8'h48); snes_wr(9'h1F5, 8'h75);
    snes_wr(9'h1F6, 8'h72); snes_wr(9'h1F7, 8'h7A);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", cheat_hit); end
    checks++; if (snescmd_unlock !== 1'b0) begin failures++; $display("FAIL rst_unlock got=%b exp=0", snescmd_unlock); end
    checks++; if (stat_count !== 16'h0) begin failures++; $display("FAIL rst_stat got=%h exp=0000", stat_count); end
    checks++; if (data_out !== 8'h2B) begin failures++; $display("FAIL rst_data got=%h exp=2b", data_out); end
    checks++; if (hit_slot !== 4'd0) begin failures++; $display("FAIL rst_slot got=%0d exp=0", hit_slot); end
  endtask

  task automatic test_priority();
    pgm(2'd0, 4'd2, {24'h7E0010, 8'h11});
    pgm(2'd0, 4'd5, {24'h7E0010, 8'h22});
    pgm(2'd1, 4'd2, 32'h1);
    pgm(2'd1, 4'd5, 32'h1);
    pgm(2'd2, 4'd0, 32'h1);
    SNES_ADDR = 24'h7E0010;
    @(negedge clk);
    checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL prio_data got=%h exp=11", data_out); end
    checks++; if (hit_slot !== 4'd2) begin failures++; $display("FAIL prio_slot got=%0d exp=2", hit_slot); end
    checks++; if (cheat_hit !== 1'b1) begin failures++; $display("FAIL prio_hit got=%b exp=1", cheat_hit); end
    pgm(2'd1, 4'd2, 32'h0);
    @(negedge clk);
    checks++; if (data_out !== 8'h22) begin failures++; $display("FAIL prio2_data got=%h exp=22", data_out); end
    checks++; if (hit_slot !== 4'd5) begin failures++; $display("FAIL prio2_slot got=%0d exp=5", hit_slot); end
    pgm(2'd2, 4'd0, 32'h10);
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL cheat_off_hit got=%b exp=0", cheat_hit); end
    pgm(2'd2, 4'd0, 32'h1);
    SNES_ADDR = 24'h7E0011;
    @(negedge clk);
    checks++; if (data_out !== 8'h2B || cheat_hit !== 1'b0) begin
      failures++; $display("FAIL nomatch got=%h/%b exp=2b/0", data_out, cheat_hit); end
  endtask

  task automatic test_oneshot();
    pgm(2'd0, 4'd0, {24'h008000, 8'hA5});
    pgm(2'd1, 4'd0, 32'h3);
    stat_idx = 4'd0;
    SNES_ADDR = 24'h008000;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'hA5) begin
      failures++; $display("FAIL os_first got=%b/%h exp=1/a5", cheat_hit, data_out); end
    snes_cycle(24'h008000);
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL os_second got=%b exp=0", cheat_hit); end
    snes_cycle(24'h008000);
    @(negedge clk);
    checks++; if (stat_count !== 16'd1) begin failures++; $display("FAIL os_stat got=%h exp=0001", stat_count); end
  endtask

  task automatic test_saturate();
    pgm(2'd0, 4'd3, {24'h7E2000, 8'h33});
    pgm(2'd1, 4'd3, 32'h1);
    stat_idx = 4'd3;
    SNES_ADDR = 24'h7E2000; SNES_cycle_start = 1'b1;
    repeat (70000) tick();
    SNES_cycle_start = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (stat_count !== 16'hFFFF) begin failures++; $display("FAIL sat_stat got=%h exp=ffff", stat_count); end
    stat_idx = 4'd9;
    tick();
    @(negedge clk);
    checks++; if (stat_count !== 16'h0) begin failures++; $display("FAIL stat_oor got=%h exp=0000", stat_count); end
    stat_idx = 4'd3;
    pgm(2'd0, 4'd3, {24'h7E2000, 8'h33});
    tick();
    @(negedge clk);
    checks++; if (stat_count !== 16'h0) begin failures++; $display("FAIL reprog_stat got=%h exp=0000", stat_count); end
  endtask

  task automatic test_nmi_hook();
    do_reset();
    pgm(2'd2, 4'd0, 32'h2);
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL nmi_presync got=%b exp=0", cheat_hit); end
    snes_cycle(24'h00FFEA);
    snes_cycle(24'h008000);
    SNES_ADDR = 24'h00FFEB;
    tick();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL nmi_one_cycle got=%b exp=0", cheat_hit); end
    snes_cycle(24'h008000);
    SNES_ADDR = 24'h00FFEB;
    tick();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'hB0) begin
      failures++; $display("FAIL nmi_hook got=%b/%h exp=1/b0", cheat_hit, data_out); end
    SNES_ADDR = 24'h00FFEA;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'h2B) begin
      failures++; $display("FAIL nmi_lo got=%b/%h exp=1/2b", cheat_hit, data_out); end
  endtask

  task automatic test_unlock_holdoff();
    int lows;
    repeat (4) snes_cycle(24'h008000);
    @(negedge clk);
    checks++; if (snescmd_unlock !== 1'b0) begin failures++; $display("FAIL temp_expire got=%b exp=0", snescmd_unlock); end
    snes_wr(9'h1F4, 8'h48); snes_wr(9'h1F5, 8'h75); snes_wr(9'h1F6, 8'h72);
    @(negedge clk);
    checks++; if (snescmd_unlock !== 1'b0) begin failures++; $display("FAIL unlock_3tok got=%b exp=0", snescmd_unlock); end
    snes_wr(9'h1F7, 8'h7A);
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (snescmd_unlock !== 1'b1) begin failures++; $display("FAIL unlock_4tok got=%b exp=1", snescmd_unlock); end
    checks++; if (cheat_hit !== 1'b1) begin failures++; $display("FAIL pre_hold_hit got=%b exp=1", cheat_hit); end
    snes_wr(9'h000, 8'h85);
    SNES_ADDR = 24'h00FFEB;
    lows = 0;
    for (int k = 0; k < HOLD + 10; k++) begin
      @(negedge clk);
      if (cheat_hit === 1'b0) lows++;
    end
    checks++; if (lows != HOLD) begin failures++; $display("FAIL holdoff_len got=%0d exp=%0d", lows, HOLD); end
    checks++; if (cheat_hit !== 1'b1) begin failures++; $display("FAIL post_hold_hit got=%b exp=1", cheat_hit); end
    snes_wr(9'h1F5, 8'h00);
    @(negedge clk);
    checks++; if (snescmd_unlock !== 1'b0) begin failures++; $display("FAIL bad_token got=%b exp=0", snescmd_unlock); end
  endtask

  task automatic test_cmd_priority();
    unlock_tokens();
    pgm(2'd0, 4'd1, {24'h7E1234, 8'h5A});
    pgm(2'd1, 4'd1, 32'h1);
    SNES_ADDR = 24'h002A00; SNES_DATA = 8'h82; snescmd_wr_strobe = 1'b1;
    pgm_sel = 2'd2; pgm_in = 32'h10; pgm_we = 1'b1;
    tick();
    snescmd_wr_strobe = 1'b0; pgm_we = 1'b0;
    SNES_ADDR = 24'h7E1234;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'h5A) begin
      failures++; $display("FAIL cmd_over_pgm got=%b/%h exp=1/5a", cheat_hit, data_out); end
    snes_wr(9'h000, 8'h83);
    SNES_ADDR = 24'h7E1234;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL cmd83 got=%b exp=0", cheat_hit); end
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1) begin failures++; $display("FAIL pre84 got=%b exp=1", cheat_hit); end
    snes_wr(9'h000, 8'h84);
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL cmd84 got=%b exp=0", cheat_hit); end
    snes_wr(9'h1F4, 8'h00);
    snes_wr(9'h000, 8'h82);
    SNES_ADDR = 24'h7E1234;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL locked_cmd got=%b exp=0", cheat_hit); end
  endtask

  task automatic test_auto_irq();
    do_reset();
    pgm(2'd2, 4'd0, 32'h4);
    repeat (40) begin snes_cycle(24'h00FFEE); tick(); end
    snes_cycle(24'h008000);
    snes_cycle(24'h008000);
    tick();
    SNES_ADDR = 24'h00FFEF;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'hC4) begin
      failures++; $display("FAIL auto_irq got=%b/%h exp=1/c4", cheat_hit, data_out); end
    pgm(2'd2, 4'd0, 32'h2);
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL auto_not_nmi got=%b exp=0", cheat_hit); end
    pgm(2'd3, 4'd0, 32'h0);
    tick(); tick();
    SNES_ADDR = 24'h00FFEF;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL mode_off got=%b exp=0", cheat_hit); end
    pgm(2'd3, 4'd0, 32'h1);
    tick(); tick();
    SNES_ADDR = 24'h00FFEB;
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1) begin failures++; $display("FAIL mode_nmi got=%b exp=1", cheat_hit); end
  endtask

  task automatic test_reset_mid();
    pgm(2'd2, 4'd0, 32'hB);
    SNES_reset_strobe = 1'b1; tick(); SNES_reset_strobe = 1'b0;
    pgm(2'd0, 4'd0, {24'h008000, 8'hA5});
    pgm(2'd1, 4'd0, 32'h3);
    snes_cycle(24'h008000);
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL mid_spent got=%b exp=0", cheat_hit); end
    stat_idx = 4'd0;
    do_reset();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0 || data_out !== 8'h2B || hit_slot !== 4'd0) begin
      failures++; $display("FAIL mid_rst_out got=%b/%h/%0d exp=0/2b/0", cheat_hit, data_out, hit_slot); end
    checks++; if (snescmd_unlock !== 1'b0 || stat_count !== 16'h0) begin
      failures++; $display("FAIL mid_rst_misc got=%b/%h exp=0/0000", snescmd_unlock, stat_count); end
    pgm(2'd1, 4'd0, 32'h1);
    pgm(2'd2, 4'd0, 32'h1);
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'hA5) begin
      failures++; $display("FAIL mid_unspent got=%b/%h exp=1/a5", cheat_hit, data_out); end
    pgm(2'd1, 4'd0, 32'h0);
    pgm(2'd2, 4'd0, 32'h2);
    snes_cycle(24'h008000);
    SNES_ADDR = 24'h00FFEB;
    tick();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b0) begin failures++; $display("FAIL mid_sync1 got=%b exp=0", cheat_hit); end
    snes_cycle(24'h008000);
    SNES_ADDR = 24'h00FFEB;
    tick();
    @(negedge clk);
    checks++; if (cheat_hit !== 1'b1 || data_out !== 8'hB0) begin
      failures++; $display("FAIL mid_hook got=%b/%h exp=1/b0", cheat_hit, data_out); end
  endtask

  initial begin
    rst = 1'b0; SNES_ADDR = 24'h0; SNES_DATA = 8'h0; SNES_cycle_start = 1'b0;
    SNES_reset_strobe = 1'b0; snescmd_wr_strobe = 1'b0; pgm_sel = 2'd0;
    pgm_idx = 4'd0; pgm_we = 1'b0; pgm_in = 32'h0; stat_idx = 4'd0;
    test_reset();
    test_priority();
    test_oneshot();
    test_saturate();
    test_nmi_hook();
    test_unlock_holdoff();
    test_cmd_priority();
    test_auto_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cheat_bank.md
CHEAT_BANK -- requirements
Module: cheat_bank

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of patch slots, legal range 1..16.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 860000000: hook holdoff length in clk cycles, stored in a 30-bit counter.
REQ-003 SHALL have parameter UNLOCK_WINDOW, default 72: number of SNES cycles the snescmd area stays temporarily unlocked after a vector fetch.
REQ-004 SHALL have parameter AUTO_WINDOW_BITS, default 21: width of the NMI/IRQ auto-select window counter.
REQ-005 SHALL use a single clock and a synchronous, active-high reset. Ports, in order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SNES_ADDR  in  24  current SNES bus address.
- SNES_DATA  in  8  SNES write data.
- SNES_cycle_start  in  1  one-clk pulse at the start of each SNES bus cycle.
- SNES_reset_strobe  in  1  one-clk pulse when the console resets.
- snescmd_wr_strobe  in  1  one-clk pulse on a SNES write to the snescmd area.
- pgm_sel  in  2  programming target: 0 slot addr/data, 1 slot control, 2 global flags, 3 hook mode.
- pgm_idx  in  4  slot index for pgm_sel 0/1.
- pgm_we  in  1  programming write strobe.
- pgm_in  in  32  programming data.
- stat_idx  in  4  slot whose hit counter is read.
- data_out  out  8  substitute data byte.
- cheat_hit  out  1  asserted when data_out overrides the bus.
- hit_slot  out  4  index of the winning slot.
- stat_count  out  16  hit count of slot stat_idx.
- snescmd_unlock  out  1  snescmd area is unlocked.

Function
REQ-006 SHALL match a slot when it is enabled, not spent, and SNES_ADDR equals its 24-bit address; the lowest-index matching slot wins. data_out and hit_slot are combinational.
REQ-007 SHALL drive data_out as follows: winning slot's data; else 8'hB0 at 00FFEB; else 8'hC4 at 00FFEF; else 8'h2B.
REQ-008 SHALL compute cheat_hit = (cheat_enable & any slot match) | (hook_en_sync & ((nmi_sel_sync & nmi_enable & addr in 00FFEA..00FFEB) | (irq_sel_sync & irq_enable & addr in 00FFEE..00FFEF))).
REQ-009 SHALL, on pgm_we with pgm_sel=0 and pgm_idx<NUM_SLOTS, load slot addr=pgm_in[31:8] and data=pgm_in[7:0], clearing that slot's spent bit and hit counter. pgm_idx>=NUM_SLOTS SHALL be ignored.
REQ-010 SHALL, on pgm_sel=1, load the slot's control bits: enable=pgm_in[0], oneshot=pgm_in[1].
REQ-011 SHALL, on pgm_sel=2, update {holdoff_enable, irq_enable, nmi_enable, cheat_enable} as (old & ~pgm_in[7:4]) | pgm_in[3:0].
REQ-012 SHALL, on pgm_sel=3, set hook_mode=pgm_in[1:0]: 0 off, 1 NMI, 2 IRQ, 3 auto.
REQ-013 SHALL, when SNES_cycle_start & cheat_enable & a slot match occur in the same cycle:
- increment the winning slot's 16-bit counter, saturating at 16'hFFFF;
- set the winning slot's spent bit the next clk if its oneshot bit is set.
REQ-014 SHALL register stat_count from stat_idx with one clk latency; an index >= NUM_SLOTS SHALL read 0.
REQ-015 SHALL run the auto-select window counter continuously, wrapping. Within each window it counts SNES_cycle_start fetches of 00FFEA (NMI) and of 00FFEE (IRQ) in 5-bit saturating counters, while hook_disable is low. When the counter reaches 0:
- NMI is selected if both counts are nonzero or the IRQ count is 0;
- else IRQ is selected if the NMI count is 0;
- both counts then restart at 0.
REQ-016 SHALL take the effective selection from hook_mode: modes 1 and 2 are forced; mode 3 uses REQ-015; mode 0 selects neither.
REQ-017 SHALL maintain a 2-bit sync_delay:
- reload to 2 on SNES_cycle_start at any vector address (00FFEA/EB/EE/EF);
- otherwise decrement on each SNES_cycle_start;
- at 0, copy nmi_sel, irq_sel and hook_en into their _sync registers.
REQ-018 SHALL define hook_en = (holdoff counter == 0) & ~hook_disable.
REQ-019 SHALL load the holdoff counter with HOLDOFF_CYCLES on snescmd command 8'h85, or on SNES_reset_strobe while holdoff_enable=1; otherwise it decrements to 0 and stops.
REQ-020 SHALL assert snescmd_unlock = (all four tokens set) | temp_unlock.
REQ-021 SHALL manage temp_unlock on SNES_cycle_start:
- at a vector address, set temp_unlock and reload its delay counter to UNLOCK_WINDOW;
- otherwise decrement the delay counter;
- clear temp_unlock when the counter is 0.
REQ-022 SHALL set unlock tokens 0..3 on snescmd writes of 48/75/72/7A to offsets 1F4/1F5/1F6/1F7. Any other write to 1F4..1F7, and SNES_reset_strobe, SHALL clear all tokens.
REQ-023 SHALL, on unlocked snescmd writes to offset 0, decode:
- 82: cheat_enable=1;
- 83: cheat_enable=0;
- 84: nmi_enable=irq_enable=0;
- 85: load holdoff (REQ-019).
An unlocked write to offset 1FD SHALL set hook_disable=SNES_DATA[0].
REQ-024 SHALL give an unlocked snescmd write priority over pgm_we in the same clk; the pgm_we write SHALL be dropped.
REQ-025 SHALL clear all slots' spent bits on SNES_reset_strobe; hit counters SHALL be kept.

Reset
REQ-026 SHALL, on rst, clear:
- all slot enables, spent bits and counters;
- cheat_enable, nmi_enable, irq_enable, holdoff_enable and hook_disable;
- the holdoff counter, tokens, temp_unlock and all _sync registers.
REQ-027 SHALL, on rst, set hook_mode=3, the auto selection to NMI, sync_delay=2 and the window counter to all ones.
REQ-028 SHALL, after rst, hold cheat_hit=0, snescmd_unlock=0, stat_count=0, data_out=8'h2B and hit_slot=0 until configuration is written.

Verification
REQ-029 SHALL cover: slots 2 and 5 both programmed to 7E0010 with data 11/22, cheat_enable=1 -> data_out=11, hit_slot=2, cheat_hit=1.
REQ-030 SHALL cover: oneshot slot 0 at 008000 with two SNES cycles there -> hit on the first cycle, no hit on the second, stat_count=1.
REQ-031 SHALL cover: 70000 hits on one slot -> stat_count=FFFF; then reprogramming the slot -> stat_count=0.
REQ-032 SHALL cover: nmi_enable=1, hook_mode=3, fetches of 00FFEA only -> cheat_hit at 00FFEB with data_out=B0, starting only after 2 non-vector cycles.
REQ-033 SHALL cover: writes 48,75,72,7A to 1F4..1F7, then 85 to offset 0 -> unlock=1 and hooks suppressed for HOLDOFF_CYCLES clks.
REQ-034 SHALL cover: rst asserted mid-holdoff with a oneshot slot spent -> all REQ-026/027 values restored.
